// File: rtl/lsu_wb_if.sv
// Bus interfaces for the lsu_wb memory/write-back stage.
//
// lsu_wb_ex_if : instruction hand-off from the execute stage.
//   master = execute stage, slave = lsu_wb.
//   ex_valid, ex_mem_r, ex_mem_w, ex_funct3, ex_addr, ex_store_data,
//   ex_alu_result, ex_rd_addr, ex_reg_w flow master->slave; ex_ready flows back.
//
// lsu_wb_dm_if : data-memory request/grant/response port.
//   master = lsu_wb, slave = data memory.
//   dm_req, dm_addr, dm_we, dm_wdata flow master->slave;
//   dm_gnt, dm_rvalid, dm_rdata flow back.

interface lsu_wb_ex_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_r;
  logic        ex_mem_w;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_w;

  modport master (
    output ex_valid, ex_mem_r, ex_mem_w, ex_funct3, ex_addr,
    output ex_store_data, ex_alu_result, ex_rd_addr, ex_reg_w,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_mem_r, ex_mem_w, ex_funct3, ex_addr,
    input  ex_store_data, ex_alu_result, ex_rd_addr, ex_reg_w,
    output ex_ready
  );
endinterface

interface lsu_wb_dm_if;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_addr, dm_we, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_addr, dm_we, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: memory-access and write-back stage of the RV32I pipeline.
//
// Accepts one instruction per ex_valid/ex_ready transfer. Non-memory ops are
// written back the following cycle. Legal, aligned loads/stores are issued to
// data memory as word-aligned requests with byte strobes; load data is shifted,
// sign/zero-extended and written back. Illegal or misaligned accesses raise a
// one-cycle mem_err pulse and touch neither memory nor the register file.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   ex         : execute-stage hand-off (slave side)
//   dm         : data-memory port (master side)
//   reg_w      : register-file write enable (single-cycle pulse)
//   rd_addr    : register-file write address (held until next write)
//   wd         : register-file write data (held until next write)
//   stall      : ~ex_ready
//   mem_err    : one-cycle pulse for misaligned access / illegal funct3
//   state_dbg  : current FSM state (0 IDLE, 1 REQ, 2 WAIT_R)
//
// Handshake rules:
//   ex : a transfer happens on a rising edge where ex_valid & ex_ready.
//        ex_ready is decoded from the state register only and never looks at
//        ex_valid.
//   dm : dm_req with dm_addr/dm_we/dm_wdata stay stable until a rising edge
//        with dm_gnt; that edge completes the request. A load response is the
//        first dm_rvalid seen after the grant edge; dm_rvalid is ignored
//        outside WAIT_R.

module lsu_wb (
  input  logic           clk,
  input  logic           rst,
  lsu_wb_ex_if.slave     ex,
  lsu_wb_dm_if.master    dm,
  output logic           reg_w,
  output logic [4:0]     rd_addr,
  output logic [31:0]    wd,
  output logic           stall,
  output logic           mem_err,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t      state;

  // Registered memory-port outputs.
  logic        dm_req_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_we_q;
  logic [31:0] dm_wdata_q;

  // Fields latched when a memory access is accepted.
  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [4:0]  lat_rd;

  // --------------------------------------------------------------------------
  // Access decode on the incoming instruction
  // --------------------------------------------------------------------------
  logic is_mem;
  logic both_ops;
  logic f3_legal;
  logic misaligned;
  logic acc_err;

  always_comb begin
    is_mem   = ex.ex_mem_r | ex.ex_mem_w;
    both_ops = ex.ex_mem_r & ex.ex_mem_w;

    f3_legal = 1'b0;
    if (ex.ex_mem_r) begin
      case (ex.ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else begin
      case (ex.ex_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end

    // funct3[1:0] carries the access size for both loads and stores.
    misaligned = ((ex.ex_funct3[1:0] == 2'b01) & ex.ex_addr[0]) |
                 ((ex.ex_funct3[1:0] == 2'b10) & (ex.ex_addr[1:0] != 2'b00));

    acc_err = both_ops | ~f3_legal | misaligned;
  end

  // --------------------------------------------------------------------------
  // Store lane steering: replicate the data across the word and select lanes
  // with the strobes so memory can write the word-aligned bus directly.
  // --------------------------------------------------------------------------
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  always_comb begin
    st_we    = 4'b1111;
    st_wdata = ex.ex_store_data;
    case (ex.ex_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << ex.ex_addr[1:0];
        st_wdata = {4{ex.ex_store_data[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << ex.ex_addr[1:0];
        st_wdata = {2{ex.ex_store_data[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = ex.ex_store_data;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load extraction: bring the addressed byte/half down to bit 0, then extend.
  // --------------------------------------------------------------------------
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    ld_shift = dm.dm_rdata >> {lat_off, 3'b000};
    case (lat_funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h000000, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0000,   ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM and all registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dm_req_q   <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_we_q    <= 4'h0;
      dm_wdata_q <= 32'h0;
      lat_load   <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      lat_rd     <= 5'd0;
      reg_w      <= 1'b0;
      rd_addr    <= 5'd0;
      wd         <= 32'h0;
      mem_err    <= 1'b0;
    end else begin
      // Pulses default low; only the cycle that produces them raises them.
      reg_w   <= 1'b0;
      mem_err <= 1'b0;

      case (state)
        IDLE: begin
          if (ex.ex_valid) begin
            if (!is_mem) begin
              // rd_addr/wd only move on an actual write so they keep the
              // last written value otherwise.
              if (ex.ex_reg_w && (ex.ex_rd_addr != 5'd0)) begin
                reg_w   <= 1'b1;
                rd_addr <= ex.ex_rd_addr;
                wd      <= ex.ex_alu_result;
              end
            end else if (acc_err) begin
              mem_err <= 1'b1;
            end else begin
              lat_load   <= ex.ex_mem_r;
              lat_funct3 <= ex.ex_funct3;
              lat_off    <= ex.ex_addr[1:0];
              lat_rd     <= ex.ex_rd_addr;
              dm_req_q   <= 1'b1;
              dm_addr_q  <= {ex.ex_addr[31:2], 2'b00};
              dm_we_q    <= ex.ex_mem_r ? 4'h0  : st_we;
              dm_wdata_q <= ex.ex_mem_r ? 32'h0 : st_wdata;
              state      <= REQ;
            end
          end
        end

        REQ: begin
          // Any dm_rvalid here is not a response to this request; ignore it.
          if (dm.dm_gnt) begin
            dm_req_q <= 1'b0;
            dm_we_q  <= 4'h0;
            state    <= lat_load ? WAIT_R : IDLE;
          end
        end

        WAIT_R: begin
          if (dm.dm_rvalid) begin
            if (lat_rd != 5'd0) begin
              reg_w   <= 1'b1;
              rd_addr <= lat_rd;
              wd      <= ld_data;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ex.ex_ready  = (state == IDLE);
  assign stall        = (state != IDLE);
  assign state_dbg    = state;

  assign dm.dm_req    = dm_req_q;
  assign dm.dm_addr   = dm_addr_q;
  assign dm.dm_we     = dm_we_q;
  assign dm.dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Testbench for lsu_wb: directed vectors with hand-computed expectations.
// Stimulus pushes expected write-backs, memory requests and error pulses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.

module tb_lsu_wb;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // DUT
  // --------------------------------------------------------------------------
  lsu_wb_ex_if ex_bus ();
  lsu_wb_dm_if dm_bus ();

  logic        reg_w;
  logic [4:0]  rd_addr;
  logic [31:0] wd;
  logic        stall;
  logic        mem_err;
  logic [1:0]  state_dbg;

  lsu_wb dut (
    .clk       (clk),
    .rst       (rst),
    .ex        (ex_bus),
    .dm        (dm_bus),
    .reg_w     (reg_w),
    .rd_addr   (rd_addr),
    .wd        (wd),
    .stall     (stall),
    .mem_err   (mem_err),
    .state_dbg (state_dbg)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  logic [36:0] exp_wb_q[$];   // {rd, wd}
  logic [71:0] exp_req_q[$];  // {held cycles[3:0], addr, we, wdata}
  logic [31:0] exp_err_q[$];  // cycle in which mem_err must be high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Memory responder: grants after gnt_lat cycles of dm_req, answers loads the
  // cycle after the grant. Drives at posedge+2.
  // --------------------------------------------------------------------------
  int          gnt_lat       = 1;
  logic [31:0] mem_rdata     = 32'h0;
  logic        hold_resp     = 1'b0;
  logic        inject_rvalid = 1'b0;
  logic [31:0] inj_rdata     = 32'h0;

  initial begin
    int   req_cycles;
    logic rv_pending;
    req_cycles = 0;
    rv_pending = 1'b0;
    dm_bus.dm_gnt    = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
    dm_bus.dm_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      dm_bus.dm_gnt    = 1'b0;
      dm_bus.dm_rvalid = 1'b0;
      if (!rst) begin
        req_cycles = 0;
        rv_pending = 1'b0;
      end else begin
        if (inject_rvalid) begin
          dm_bus.dm_rvalid = 1'b1;
          dm_bus.dm_rdata  = inj_rdata;
        end
        if (rv_pending) begin
          dm_bus.dm_rvalid = 1'b1;
          dm_bus.dm_rdata  = mem_rdata;
          rv_pending       = 1'b0;
        end
        if (dm_bus.dm_req) begin
          req_cycles++;
          if (req_cycles >= gnt_lat) begin
            dm_bus.dm_gnt = 1'b1;
            req_cycles    = 0;
            if (dm_bus.dm_we == 4'h0 && !hold_resp) rv_pending = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  int req_run = 0;

  always @(negedge clk) begin
    logic [36:0] ew;
    logic [71:0] er;
    if (!rst) begin
      req_run = 0;
    end else begin
      if (mem_err) begin
        if (exp_err_q.size() == 0) fail_event("unexpected_mem_err");
        else check("mem_err_cycle", cyc, exp_err_q.pop_front());
      end
      if (reg_w) begin
        if (exp_wb_q.size() == 0) fail_event("unexpected_reg_w");
        else begin
          ew = exp_wb_q.pop_front();
          check("wb_rd_addr", {27'h0, rd_addr}, {27'h0, ew[36:32]});
          check("wb_data", wd, ew[31:0]);
        end
      end
      if (dm_bus.dm_req) begin
        req_run++;
        if (exp_req_q.size() == 0) fail_event("unexpected_dm_req");
        else begin
          er = exp_req_q[0];
          check("req_addr", dm_bus.dm_addr, er[67:36]);
          check("req_we", {28'h0, dm_bus.dm_we}, {28'h0, er[35:32]});
          check("req_wdata", dm_bus.dm_wdata, er[31:0]);
          if (dm_bus.dm_gnt) begin
            check("req_held_cycles", req_run, {28'h0, er[71:68]});
            void'(exp_req_q.pop_front());
            req_run = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, output int acc_cyc);
    int   guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    ex_bus.ex_mem_r      = mr;
    ex_bus.ex_mem_w      = mw;
    ex_bus.ex_funct3     = f3;
    ex_bus.ex_addr       = addr;
    ex_bus.ex_store_data = sdata;
    ex_bus.ex_alu_result = alu;
    ex_bus.ex_rd_addr    = rd;
    ex_bus.ex_reg_w      = rw;
    ex_bus.ex_valid      = 1'b1;
    while (!took && guard < 100) begin
      took = ex_bus.ex_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    ex_bus.ex_valid = 1'b0;
    if (!took) fail_event("accept_timeout");
    acc_cyc = cyc;
  endtask

  // Counts the edges until ex_ready returns, starting just after acceptance.
  task automatic wait_idle(output int n);
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_req(input logic [3:0] held, input logic [31:0] addr,
                          input logic [3:0] we, input logic [31:0] wdata);
    exp_req_q.push_back({held, addr, we, wdata});
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    exp_wb_q.push_back({rd, data});
  endtask

  // --------------------------------------------------------------------------
  // Vector tables
  // --------------------------------------------------------------------------
  localparam int NL = 6;
  logic [2:0]  ld_f3   [NL] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b001, 3'b010};
  logic [31:0] ld_addr [NL] = '{32'h102, 32'h102, 32'h101, 32'h100, 32'h200, 32'h204};
  logic [31:0] ld_rdata[NL] = '{32'h80FF_0000, 32'h80FF_0000, 32'h1234_F678,
                                32'h1234_F678, 32'h1234_F678, 32'h89AB_CDEF};
  logic [31:0] ld_exp  [NL] = '{32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_FFF6,
                                32'h0000_0078, 32'hFFFF_F678, 32'h89AB_CDEF};

  localparam int NS = 4;
  logic [2:0]  st_f3   [NS] = '{3'b000, 3'b000, 3'b001, 3'b010};
  logic [31:0] st_addr [NS] = '{32'h301, 32'h303, 32'h200, 32'h404};
  logic [31:0] st_data [NS] = '{32'h1234_56A5, 32'h0000_00FF, 32'h0000_1357, 32'hCAFE_F00D};
  logic [3:0]  st_we   [NS] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111};
  logic [31:0] st_wdat [NS] = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h1357_1357, 32'hCAFE_F00D};

  localparam int NE = 5;
  logic        er_mr  [NE] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        er_mw  [NE] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0]  er_f3  [NE] = '{3'b010, 3'b011, 3'b001, 3'b010, 3'b100};
  logic [31:0] er_addr[NE] = '{32'h101, 32'h100, 32'h203, 32'h100, 32'h100};

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int acc;
    int n;
    int c1;
    int c2;
    int c3;

    ex_bus.ex_valid      = 1'b0;
    ex_bus.ex_mem_r      = 1'b0;
    ex_bus.ex_mem_w      = 1'b0;
    ex_bus.ex_funct3     = 3'b000;
    ex_bus.ex_addr       = 32'h0;
    ex_bus.ex_store_data = 32'h0;
    ex_bus.ex_alu_result = 32'h0;
    ex_bus.ex_rd_addr    = 5'd0;
    ex_bus.ex_reg_w      = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #12;
    check("rst_ex_ready", {31'h0, ex_bus.ex_ready}, 32'h1);
    check("rst_dm_req", {31'h0, dm_bus.dm_req}, 32'h0);
    check("rst_dm_we", {28'h0, dm_bus.dm_we}, 32'h0);
    check("rst_dm_addr", dm_bus.dm_addr, 32'h0);
    check("rst_reg_w", {31'h0, reg_w}, 32'h0);
    check("rst_mem_err", {31'h0, mem_err}, 32'h0);
    check("rst_wd", wd, 32'h0);
    check("rst_rd_addr", {27'h0, rd_addr}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(1);

    // ALU ops
    push_wb(5'd5, 32'h1234_5678);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, acc);
    check("alu_reg_w_next_cycle", {31'h0, reg_w}, 32'h1);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_0000, 5'd0, 1'b1, acc);
    check("alu_rd0_no_write", {31'h0, reg_w}, 32'h0);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0BAD_0BAD, 5'd7, 1'b0, acc);
    check("alu_regw0_no_write", {31'h0, reg_w}, 32'h0);
    check("alu_wd_held", wd, 32'h1234_5678);
    idle_cycles(1);

    // LB / LBU at 0x103 with a three-cycle grant
    gnt_lat   = 3;
    mem_rdata = 32'h80FF_0000;
    push_req(4'd3, 32'h100, 4'h0, 32'h0);
    push_wb(5'd6, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd6, 1'b1, acc);
    wait_idle(n);
    check("lb_stall_cycles", n, 32'd4);
    check("lb_wb_with_ready", {31'h0, reg_w}, 32'h1);
    idle_cycles(1);
    push_req(4'd3, 32'h100, 4'h0, 32'h0);
    push_wb(5'd6, 32'h0000_0080);
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 5'd6, 1'b1, acc);
    wait_idle(n);
    check("lbu_stall_cycles", n, 32'd4);
    idle_cycles(1);

    // Load table, immediate grant
    gnt_lat = 1;
    for (int i = 0; i < NL; i++) begin
      mem_rdata = ld_rdata[i];
      push_req(4'd1, {ld_addr[i][31:2], 2'b00}, 4'h0, 32'h0);
      push_wb(5'(10 + i), ld_exp[i]);
      issue(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0, 32'h0, 5'(10 + i), 1'b1, acc);
      wait_idle(n);
      check("load_stall_cycles", n, 32'd2);
    end
    idle_cycles(1);

    // SH at 0x202, grant after two cycles
    gnt_lat = 2;
    push_req(4'd2, 32'h200, 4'b1100, 32'hBEEF_BEEF);
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0, 5'd3, 1'b1, acc);
    wait_idle(n);
    check("sh_stall_cycles", n, 32'd2);
    idle_cycles(1);

    // Store table, immediate grant
    gnt_lat = 1;
    for (int i = 0; i < NS; i++) begin
      push_req(4'd1, {st_addr[i][31:2], 2'b00}, st_we[i], st_wdat[i]);
      issue(1'b0, 1'b1, st_f3[i], st_addr[i], st_data[i], 32'h0, 5'd4, 1'b1, acc);
      wait_idle(n);
      check("store_stall_cycles", n, 32'd1);
    end
    idle_cycles(1);

    // Illegal / misaligned accesses
    for (int i = 0; i < NE; i++) begin
      issue(er_mr[i], er_mw[i], er_f3[i], er_addr[i], 32'h5555_5555, 32'h0, 5'd8, 1'b1, acc);
      exp_err_q.push_back(acc);
      check("err_no_dm_req", {31'h0, dm_bus.dm_req}, 32'h0);
      check("err_no_stall", {31'h0, stall}, 32'h0);
    end
    idle_cycles(2);

    // Back-to-back ALU, LW, ALU
    gnt_lat   = 1;
    mem_rdata = 32'hDEAD_BEEF;
    push_wb(5'd1, 32'h0000_0011);
    push_req(4'd1, 32'h500, 4'h0, 32'h0);
    push_wb(5'd2, 32'hDEAD_BEEF);
    push_wb(5'd3, 32'h0000_0033);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0011, 5'd1, 1'b1, c1);
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 5'd2, 1'b1, c2);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0033, 5'd3, 1'b1, c3);
    check("b2b_lw_accept_gap", c2 - c1, 32'd1);
    check("b2b_total_cycles", c3 - c1, 32'd4);
    idle_cycles(2);

    // Reset while in WAIT_R, then a stale response
    hold_resp = 1'b1;
    push_req(4'd1, 32'h300, 4'h0, 32'h0);
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1, acc);
    idle_cycles(1);
    check("in_wait_r", {30'h0, state_dbg}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ex_ready", {31'h0, ex_bus.ex_ready}, 32'h1);
    check("rst_mid_state", {30'h0, state_dbg}, 32'd0);
    check("rst_mid_wd", wd, 32'h0);
    check("rst_mid_rd_addr", {27'h0, rd_addr}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    hold_resp     = 1'b0;
    inj_rdata     = 32'h5A5A_5A5A;
    inject_rvalid = 1'b1;
    @(posedge clk);
    #1 inject_rvalid = 1'b0;
    idle_cycles(1);
    check("stale_rvalid_reg_w", {31'h0, reg_w}, 32'h0);
    check("stale_rvalid_state", {30'h0, state_dbg}, 32'd0);
    check("stale_rvalid_wd", wd, 32'h0);
    check("stale_rvalid_dm_req", {31'h0, dm_bus.dm_req}, 32'h0);
    idle_cycles(3);

    // Everything expected must have been observed
    check("wb_queue_drained", exp_wb_q.size(), 32'd0);
    check("req_queue_drained", exp_req_q.size(), 32'd0);
    check("err_queue_drained", exp_err_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Memory-access and write-back stage of the pipelined RV32I core. Accepts one instruction per handshake from the execute stage and issues aligned loads and stores to the data-memory port through a request/grant/response handshake. Sign- or zero-extends load data, then drives the register file's write port (`reg_w`, `rd_addr`, `wd`). While a memory access is outstanding it back-pressures the pipeline.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports (name, direction, width, meaning):
- `clk` in 1 — single clock; all state on rising edge.
- `rst` in 1 — reset, asynchronous, active-low (asserted at 0).
- `ex_valid` in 1 — execute stage presents an instruction.
- `ex_ready` out 1 — stage can accept; a transfer occurs when `ex_valid & ex_ready`.
- `ex_mem_r` / `ex_mem_w` in 1 each — load / store.
- `ex_funct3` in 3 — access size and sign.
- `ex_addr` in 32 — effective byte address.
- `ex_store_data` in 32 — rs2 value for stores.
- `ex_alu_result` in 32 — write-back value for non-memory ops.
- `ex_rd_addr` in 5, `ex_reg_w` in 1 — destination register and its write enable.
- `dm_req` out 1, `dm_addr` out 32 (word aligned, [1:0]=0), `dm_we` out 4 (byte strobes, 0 = read), `dm_wdata` out 32 — memory request.
- `dm_gnt` in 1 — memory accepts the request this cycle.
- `dm_rvalid` in 1, `dm_rdata` in 32 — read response.
- `reg_w` out 1, `rd_addr` out 5, `wd` out 32 — register-file write port.
- `stall` out 1 — equals `~ex_ready`.
- `mem_err` out 1 — one-cycle pulse: misaligned access or illegal funct3.

## Operation
- States: IDLE, REQ, WAIT_R. `ex_ready` = (state == IDLE).
- IDLE, transfer, no memory op: next cycle `reg_w` = `ex_reg_w & (ex_rd_addr != 0)`, `wd` = `ex_alu_result`. Stay in IDLE, so back-to-back transfers are allowed.
- IDLE, transfer, load or store, legal and aligned: latch the fields and go to REQ.
  - Store strobes: SB `4'b0001 << addr[1:0]` with `wdata` = `{4{data[7:0]}}`; SH `4'b0011 << addr[1:0]` with `{2{data[15:0]}}`; SW `4'b1111`.
  - Loads: `dm_we` = 0.
- REQ: hold `dm_req`, `dm_addr`, `dm_we` and `dm_wdata` stable until `dm_gnt`.
  - Store granted → IDLE; no register write.
  - Load granted → WAIT_R.
- WAIT_R: wait for `dm_rvalid` (ignored in any other state). On `dm_rvalid`:
  - Form `b = dm_rdata >> (8*addr[1:0])`. LB sign-extends `b[7:0]`, LBU zero-extends it, LH sign-extends `b[15:0]`, LHU zero-extends it, LW passes all 32 bits.
  - Register the result into `wd`, set `reg_w` = (`rd` != 0), go to IDLE.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
- Misalignment: half-word with addr[0]=1, or word with addr[1:0]≠0.
- Illegal funct3, misalignment, or `ex_mem_r & ex_mem_w`: no memory request and no register write; `mem_err` = 1 next cycle; stay in IDLE.
- `reg_w` and `mem_err` are single-cycle pulses. `rd_addr` and `wd` hold their value until the next write.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `dm_req`, `dm_we`, `reg_w` and `mem_err` are 0; `dm_addr`, `dm_wdata`, `rd_addr` and `wd` are 0. `ex_ready` is 1 as soon as reset asserts.
- Reset during REQ or WAIT_R abandons the access. `dm_req` drops immediately, and a late `dm_rvalid` after reset is ignored.
- All `dm_*`, `reg_w`, `rd_addr`, `wd` and `mem_err` outputs are registered. `ex_ready` and `stall` are decoded from the state register only and never depend on `ex_valid`.
- Non-memory op accepted at edge N → `reg_w` high during cycle N+1.
- Load accepted at edge N → `dm_req` high from cycle N+1. With `dm_gnt` at edge N+1 and `dm_rvalid` at edge N+2, `reg_w` is high during cycle N+3, which is also when `ex_ready` returns to 1.
- Store with immediate grant: `ex_ready` = 0 for exactly one cycle.
- `dm_gnt` and `dm_rvalid` in the same cycle while in REQ: `dm_rvalid` is ignored. The memory must return the response at least one cycle after the grant.

## Test plan
- Reset then ALU op: `ex_alu_result`=0x1234_5678, rd=5 → one cycle later `reg_w`=1, `rd_addr`=5, `wd`=0x1234_5678. With rd=0 → `reg_w`=0.
- LB at 0x103, memory returns 0x80FF_0000 with 3-cycle grant delay → `dm_addr`=0x100, `dm_req` held 3 cycles, `wd`=0xFFFF_FF80. Same access as LBU → `wd`=0x0000_0080.
- SH at 0x202, data 0xAAAA_BEEF → `dm_we`=4'b1100, `dm_wdata`=0xBEEF_BEEF, no `reg_w` pulse, `stall` high until grant.
- LW at 0x101 → `mem_err` pulses 1 cycle, `dm_req` stays 0, `reg_w` stays 0. Same outcome for funct3=011 with `ex_mem_r`=1.
- Back-to-back: ALU, LW (rdata 0xDEAD_BEEF), ALU presented continuously → writes in order, LW `wd`=0xDEAD_BEEF, `ex_ready` low only during REQ and WAIT_R.
- Assert `rst`=0 while in WAIT_R, then pulse `dm_rvalid` after release → no `reg_w`, state IDLE, all outputs 0.
